// File: rtl/hazard_pkg.sv
// Shared encodings for the pipeline hazard controller: result-select code
// for loads, forwarding-mux selects and the memory-sequencing FSM states.
package hazard_pkg;

  localparam logic [1:0] RESULT_MEM = 2'b01;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } state_t;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-facing signal bundle of the hazard controller. The pipeline side
// (master) supplies register indices and memory handshake status; the
// controller side (slave) returns stall/flush/forward controls and counters.
interface hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       Rs1D;
  logic [4:0]       Rs2D;
  logic [4:0]       Rs1E;
  logic [4:0]       Rs2E;
  logic [4:0]       RdE;
  logic [1:0]       ResultSrcE;
  logic             PCSrcE;
  logic [4:0]       RdM;
  logic             RegWriteM;
  logic [4:0]       RdW;
  logic             RegWriteW;
  logic             MemReqM;
  logic             MemReadyM;

  logic             StallF;
  logic             StallD;
  logic             FlushD;
  logic             StallE;
  logic             FlushE;
  logic             StallM;
  logic             FlushW;
  logic [1:0]       ForwardAE;
  logic [1:0]       ForwardBE;
  logic             BusErr;
  logic [CNT_W-1:0] StallCnt;
  logic [CNT_W-1:0] FlushCnt;

  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, ResultSrcE, PCSrcE,
           RdM, RegWriteM, RdW, RegWriteW, MemReqM, MemReadyM,
    input  StallF, StallD, FlushD, StallE, FlushE, StallM, FlushW,
           ForwardAE, ForwardBE, BusErr, StallCnt, FlushCnt
  );

  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, ResultSrcE, PCSrcE,
           RdM, RegWriteM, RdW, RegWriteW, MemReqM, MemReadyM,
    output StallF, StallD, FlushD, StallE, FlushE, StallM, FlushW,
           ForwardAE, ForwardBE, BusErr, StallCnt, FlushCnt
  );

endinterface

// File: rtl/hazard_ctrl_fwd_unit.sv
// EX-stage operand forwarding select for one source operand. The Memory
// stage holds the younger result, so it wins over Writeback; x0 is never
// forwarded because it is hardwired to zero.
module fwd_unit
  import hazard_pkg::*;
(
  input  logic [4:0] rs_e,
  input  logic [4:0] rd_m,
  input  logic       reg_write_m,
  input  logic [4:0] rd_w,
  input  logic       reg_write_w,
  output logic [1:0] fwd
);

  // Priority select: Memory result, then Writeback result, then register file.
  always_comb begin
    fwd = FWD_RF;
    if (reg_write_m && (rd_m != 5'd0) && (rd_m == rs_e)) begin
      fwd = FWD_MEM;
    end else if (reg_write_w && (rd_w != 5'd0) && (rd_w == rs_e)) begin
      fwd = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Central stall/flush/forward controller for the 5-stage core, with data-bus
// wait-state sequencing, a timeout watchdog and stall/flush counters.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// RUN      | normal flow; load-use and branch hazards handled here
// MEM_WAIT | data access outstanding; whole pipeline frozen up to Memory
// ERR      | bus timeout; pipeline frozen until reset, BusErr held high
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input logic          clk,
  input logic          rst,
  hazard_ctrl_if.slave bus
);

  localparam logic [7:0] TIMEOUT_C = 8'(MEM_TIMEOUT);

  state_t           state_q, state_d;
  logic [7:0]       wait_cnt_q, wait_cnt_d;
  logic             bus_err_q, bus_err_d;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  logic lw_stall, mem_wait, freeze;
  logic stall_f, stall_d, flush_d, stall_e, flush_e, stall_m, flush_w;
  logic [1:0] fwd_a, fwd_b;

  fwd_unit u_fwd_a (
    .rs_e        (bus.Rs1E),
    .rd_m        (bus.RdM),
    .reg_write_m (bus.RegWriteM),
    .rd_w        (bus.RdW),
    .reg_write_w (bus.RegWriteW),
    .fwd         (fwd_a)
  );

  fwd_unit u_fwd_b (
    .rs_e        (bus.Rs2E),
    .rd_m        (bus.RdM),
    .reg_write_m (bus.RegWriteM),
    .rd_w        (bus.RdW),
    .reg_write_w (bus.RegWriteW),
    .fwd         (fwd_b)
  );

  assign lw_stall = (bus.ResultSrcE == RESULT_MEM) && (bus.RdE != 5'd0) &&
                    ((bus.RdE == bus.Rs1D) || (bus.RdE == bus.Rs2D));
  assign mem_wait = bus.MemReqM && !bus.MemReadyM;

  // Next-state and pipeline controls. While frozen, E cannot advance, so any
  // branch flush or load-use bubble is deferred until the access completes.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    bus_err_d  = bus_err_q;
    freeze     = 1'b0;

    case (state_q)
      RUN: begin
        if (mem_wait) begin
          freeze     = 1'b1;
          state_d    = MEM_WAIT;
          wait_cnt_d = 8'd1;
        end
      end
      MEM_WAIT: begin
        if (bus.MemReadyM) begin
          state_d    = RUN;
          wait_cnt_d = 8'd0;
        end else begin
          freeze = 1'b1;
          if (wait_cnt_q == TIMEOUT_C) begin
            state_d   = ERR;
            bus_err_d = 1'b1;
          end else if (wait_cnt_q != 8'hFF) begin
            wait_cnt_d = wait_cnt_q + 8'd1;
          end
        end
      end
      ERR: begin
        freeze = 1'b1;
      end
      default: begin
        state_d = RUN;
      end
    endcase

    stall_f = lw_stall && !bus.PCSrcE;
    stall_d = lw_stall && !bus.PCSrcE;
    flush_d = bus.PCSrcE;
    flush_e = lw_stall || bus.PCSrcE;
    stall_e = 1'b0;
    stall_m = 1'b0;
    flush_w = 1'b0;

    if (freeze) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
      stall_m = 1'b1;
      flush_w = 1'b1;
      flush_d = 1'b0;
      flush_e = 1'b0;
    end

    if (rst) begin
      stall_f = 1'b0;
      stall_d = 1'b0;
      stall_e = 1'b0;
      stall_m = 1'b0;
      flush_d = 1'b1;
      flush_e = 1'b1;
      flush_w = 1'b1;
    end
  end

  // State, wait timer, sticky error flag and performance counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      wait_cnt_q  <= 8'd0;
      bus_err_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      bus_err_q  <= bus_err_d;
      if (stall_f) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (flush_e) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign bus.StallF    = stall_f;
  assign bus.StallD    = stall_d;
  assign bus.FlushD    = flush_d;
  assign bus.StallE    = stall_e;
  assign bus.FlushE    = flush_e;
  assign bus.StallM    = stall_m;
  assign bus.FlushW    = flush_w;
  assign bus.ForwardAE = rst ? FWD_RF : fwd_a;
  assign bus.ForwardBE = rst ? FWD_RF : fwd_b;
  assign bus.BusErr    = bus_err_q;
  assign bus.StallCnt  = stall_cnt_q;
  assign bus.FlushCnt  = flush_cnt_q;

endmodule
